// File: rtl/dmem_pkg.sv
// Shared encodings and the alignment check for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // True when the access size is illegal or the lane offset breaks natural alignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lane[0];
      SIZE_WORD: return lane != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store request and response channels between the MEM stage and the data RAM.
interface dmem_if;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_write_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic [1:0]  req_size_in;
  logic        req_unsigned_in;
  logic        resp_valid_out;
  logic        resp_ready_in;
  logic [31:0] resp_rdata_out;
  logic        resp_err_out;
  logic        busy_out;

  modport master (
    output req_valid_in, req_write_in, req_addr_in, req_wdata_in, req_size_in,
           req_unsigned_in, resp_ready_in,
    input  req_ready_out, resp_valid_out, resp_rdata_out, resp_err_out, busy_out
  );

  modport slave (
    input  req_valid_in, req_write_in, req_addr_in, req_wdata_in, req_size_in,
           req_unsigned_in, resp_ready_in,
    output req_ready_out, resp_valid_out, resp_rdata_out, resp_err_out, busy_out
  );
endinterface

// File: rtl/dmem_load_align.sv
// Extracts the addressed byte/half/word from a RAM word and sign- or zero-extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // NOTE: every variable driven here gets a default first, so no path can leave a latch behind.
  always_comb begin
    shifted = word >> {lane, 3'b000};
    data    = shifted;
    case (size)
      SIZE_BYTE: data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default:   data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data RAM behind a valid/ready request/response pair, with
// programmable wait states and byte/half/word access including error flagging.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);

  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             commit;

  logic             write_q, unsigned_q;
  logic [31:0]      addr_q, wdata_q;
  logic [1:0]       size_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic [31:0]      mem [DEPTH];

  logic                  cur_write, cur_unsigned, cur_err;
  logic [31:0]           cur_addr, cur_wdata, wdata_rep, ram_word, load_val;
  logic [1:0]            cur_size;
  logic [ADDR_WIDTH-1:0] cur_index;
  logic [3:0]            byte_en;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // commit marks the edge that enters RESP: RAM write and load capture happen there.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid_in) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accept edge, before the latches load.
  always_comb begin
    if (state == IDLE) begin
      cur_write    = bus.req_write_in;
      cur_addr     = bus.req_addr_in;
      cur_wdata    = bus.req_wdata_in;
      cur_size     = bus.req_size_in;
      cur_unsigned = bus.req_unsigned_in;
    end else begin
      cur_write    = write_q;
      cur_addr     = addr_q;
      cur_wdata    = wdata_q;
      cur_size     = size_q;
      cur_unsigned = unsigned_q;
    end
  end

  assign cur_err   = misaligned(cur_size, cur_addr[1:0]) ||
                     (cur_addr[31:ADDR_WIDTH+2] != '0);
  assign cur_index = cur_addr[ADDR_WIDTH+1:2];
  assign ram_word  = mem[cur_index];

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = cur_wdata;
    case (cur_size)
      SIZE_BYTE: begin
        byte_en   = 4'b0001 << cur_addr[1:0];
        wdata_rep = {4{cur_wdata[7:0]}};
      end
      SIZE_HALF: begin
        byte_en   = cur_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{cur_wdata[15:0]}};
      end
      SIZE_WORD: byte_en = 4'b1111;
      default:   byte_en = 4'b0000;
    endcase
  end

  // NOTE: the RAM array has no reset; only the control and response registers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && commit && cur_write && !cur_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[cur_index][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  dmem_load_align u_align (
    .word        (ram_word),
    .lane        (cur_addr[1:0]),
    .size        (cur_size),
    .is_unsigned (cur_unsigned),
    .data        (load_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SIZE_BYTE;
      unsigned_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid_in) begin
        write_q    <= bus.req_write_in;
        addr_q     <= bus.req_addr_in;
        wdata_q    <= bus.req_wdata_in;
        size_q     <= bus.req_size_in;
        unsigned_q <= bus.req_unsigned_in;
      end
      if (commit) begin
        err_q   <= cur_err;
        rdata_q <= (cur_err || cur_write) ? '0 : load_val;
      end
    end
  end

  assign bus.req_ready_out  = (state == IDLE);
  assign bus.resp_valid_out = (state == RESP);
  assign bus.busy_out       = (state != IDLE);
  assign bus.resp_rdata_out = rdata_q;
  assign bus.resp_err_out   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a byte-addressed reference memory predicts every
// response of a 2-wait-state instance and a 0-wait-state instance.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int AW     = 10;
  localparam int W_SLOW = 2;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // sel = 0 drives the 2-wait instance, sel = 1 the 0-wait instance
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = SIZE_WORD;

  dmem_if bus_slow ();
  dmem_if bus_fast ();

  assign bus_slow.req_valid_in    = req_valid && !sel;
  assign bus_slow.req_write_in    = req_write;
  assign bus_slow.req_addr_in     = req_addr;
  assign bus_slow.req_wdata_in    = req_wdata;
  assign bus_slow.req_size_in     = req_size;
  assign bus_slow.req_unsigned_in = req_unsigned;
  assign bus_slow.resp_ready_in   = sel ? 1'b1 : resp_ready;

  assign bus_fast.req_valid_in    = req_valid && sel;
  assign bus_fast.req_write_in    = req_write;
  assign bus_fast.req_addr_in     = req_addr;
  assign bus_fast.req_wdata_in    = req_wdata;
  assign bus_fast.req_size_in     = req_size;
  assign bus_fast.req_unsigned_in = req_unsigned;
  assign bus_fast.resp_ready_in   = sel ? resp_ready : 1'b1;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W_SLOW)) dut_slow (
    .clk (clk),
    .rst (rst),
    .bus (bus_slow)
  );

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut_fast (
    .clk (clk),
    .rst (rst),
    .bus (bus_fast)
  );

  logic        ready, valid, busy, err;
  logic [31:0] rdata;
  assign ready = sel ? bus_fast.req_ready_out  : bus_slow.req_ready_out;
  assign valid = sel ? bus_fast.resp_valid_out : bus_slow.resp_valid_out;
  assign busy  = sel ? bus_fast.busy_out       : bus_slow.busy_out;
  assign err   = sel ? bus_fast.resp_err_out   : bus_slow.resp_err_out;
  assign rdata = sel ? bus_fast.resp_rdata_out : bus_slow.resp_rdata_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: one byte per address ----------------
  logic [7:0] mem_slow [int unsigned];
  logic [7:0] mem_fast [int unsigned];

  function automatic logic [7:0] mem_get(input logic s, input int unsigned a);
    if (s) return mem_fast.exists(a) ? mem_fast[a] : 8'hxx;
    return mem_slow.exists(a) ? mem_slow[a] : 8'hxx;
  endfunction

  function automatic void mem_set(input logic s, input int unsigned a, input logic [7:0] d);
    if (s) mem_fast[a] = d;
    else   mem_slow[a] = d;
  endfunction

  function automatic void model(input logic s, input req_t r,
                                output logic [31:0] rd, output logic er);
    int          nb;
    logic [31:0] v;
    rd = '0;
    er = 1'b0;
    nb = (r.size == 2'b11) ? 0 : (1 << r.size);
    if (nb == 0)                      er = 1'b1;
    else if (r.addr >= 32'(4 << AW))  er = 1'b1;
    else if ((r.addr % nb) != 0)      er = 1'b1;
    if (!er) begin
      if (r.wr) begin
        for (int i = 0; i < nb; i++) mem_set(s, r.addr + i, r.wdata[8*i +: 8]);
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(mem_get(s, r.addr + i)) << (8 * i));
        if (!r.uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 1);
        rd = v;
      end
    end
  endfunction

  // ---------------- compare process ----------------
  req_t        pend;
  logic        have_pend = 1'b0, in_resp = 1'b0;
  int          acc_cyc = 0;
  int          lat_exp;
  logic [31:0] exp_rd = '0;
  logic        exp_err = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      check("reset_ctrl", {ready, valid, busy, err}, 4'b1000);
      check("reset_rdata", rdata, 32'h0);
      have_pend = 1'b0;
      in_resp   = 1'b0;
    end else begin
      lat_exp = (sel ? 0 : W_SLOW) + 1;
      check("ready_vs_outstanding", ready, !(have_pend || in_resp));
      check("busy_vs_outstanding", busy, have_pend || in_resp);
      if (valid && !in_resp) begin
        if (have_pend) begin
          check("resp_latency", cyc - acc_cyc, lat_exp);
          model(sel, pend, exp_rd, exp_err);
          have_pend = 1'b0;
          in_resp   = 1'b1;
        end else begin
          check("spurious_resp", valid, 1'b0);
        end
      end
      if (valid && in_resp) begin
        check("model_rdata", rdata, exp_rd);
        check("model_err", err, exp_err);
      end
      if (have_pend && !valid && (cyc - acc_cyc > lat_exp)) check("resp_missing", valid, 1'b1);
      if (valid && resp_ready) in_resp = 1'b0;
      if (req_valid && ready) begin
        pend      = '{wr: req_write, addr: req_addr, wdata: req_wdata, size: req_size, uns: req_unsigned};
        have_pend = 1'b1;
        acc_cyc   = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", ready, 1'b1);
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("resp_timeout", valid, 1'b1);
  endtask

  task automatic drive(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns);
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = a;
    req_wdata    = wd;
    req_size     = sz;
    req_unsigned = uns;
  endtask

  task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic uns,
                      output logic [31:0] rd, output logic er, output int lat);
    int acc;
    @(posedge clk); #1;
    drive(wr, a, wd, sz, uns);
    resp_ready = 1'b1;
    wait_ready();
    acc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_valid();
    rd  = rdata;
    er  = err;
    lat = cyc - acc;
  endtask

  task automatic ld(input string nm, input logic [31:0] a, input logic [1:0] sz, input logic uns,
                    input logic [31:0] exp_rdata, input logic exp_e);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(1'b0, a, 32'h0, sz, uns, rd, er, lat);
    check({nm, "_rdata"}, rd, exp_rdata);
    check({nm, "_err"}, er, exp_e);
  endtask

  task automatic st(input string nm, input logic [31:0] a, input logic [31:0] wd,
                    input logic [1:0] sz, input logic exp_e);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(1'b1, a, wd, sz, 1'b0, rd, er, lat);
    check({nm, "_rdata"}, rd, 32'h0);
    check({nm, "_err"}, er, exp_e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [31:0] byte_exp [4] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state_ctrl", {ready, valid, busy, err}, 4'b1000);
    check("reset_state_rdata", rdata, 32'h0);
    rst = 1'b0;

    // basic store/load and 3-cycle latency
    st("st_word_10", 32'h10, 32'hDEADBEEF, SIZE_WORD, 1'b0);
    xact(1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, rd, er, lat);
    check("ld_word_10_rdata", rd, 32'hDEADBEEF);
    check("ld_word_10_err", er, 1'b0);
    check("ld_word_10_latency", lat, 3);

    // lane extraction and extension
    st("st_word_20", 32'h20, 32'h80FF7F01, SIZE_WORD, 1'b0);
    for (int i = 0; i < 4; i++) ld("ld_byte_signed", 32'h20 + i, SIZE_BYTE, 1'b0, byte_exp[i], 1'b0);
    ld("ld_byte_unsigned_23", 32'h23, SIZE_BYTE, 1'b1, 32'h00000080, 1'b0);
    ld("ld_half_signed_22", 32'h22, SIZE_HALF, 1'b0, 32'hFFFF80FF, 1'b0);
    ld("ld_half_unsigned_20", 32'h20, SIZE_HALF, 1'b1, 32'h00007F01, 1'b0);
    ld("ld_word_ignores_uns", 32'h20, SIZE_WORD, 1'b1, 32'h80FF7F01, 1'b0);

    // partial stores
    st("st_word_20b", 32'h20, 32'h11223344, SIZE_WORD, 1'b0);
    st("st_byte_21", 32'h21, 32'h123456AA, SIZE_BYTE, 1'b0);
    ld("ld_after_byte_st", 32'h20, SIZE_WORD, 1'b0, 32'h1122AA44, 1'b0);
    st("st_half_22", 32'h22, 32'h7777BEEF, SIZE_HALF, 1'b0);
    ld("ld_after_half_st", 32'h20, SIZE_WORD, 1'b0, 32'hBEEFAA44, 1'b0);

    // error cases and range boundary
    ld("err_half_odd", 32'h21, SIZE_HALF, 1'b0, 32'h0, 1'b1);
    ld("err_word_unaligned", 32'h22, SIZE_WORD, 1'b0, 32'h0, 1'b1);
    ld("err_size_11", 32'h20, 2'b11, 1'b0, 32'h0, 1'b1);
    ld("err_range", 32'h1000, SIZE_WORD, 1'b0, 32'h0, 1'b1);
    st("err_store_unaligned", 32'h22, 32'hFFFFFFFF, SIZE_WORD, 1'b1);
    st("err_store_range", 32'h1000, 32'h0000_0001, SIZE_WORD, 1'b1);
    ld("readback_after_err", 32'h20, SIZE_WORD, 1'b0, 32'hBEEFAA44, 1'b0);
    st("st_last_word", 32'hFFC, 32'h5A5AA5A5, SIZE_WORD, 1'b0);
    ld("ld_last_word", 32'hFFC, SIZE_WORD, 1'b0, 32'h5A5AA5A5, 1'b0);

    // response back-pressure with a second request waiting
    @(posedge clk); #1;
    drive(1'b0, 32'h20, 32'h0, SIZE_WORD, 1'b0);
    resp_ready = 1'b0;
    wait_ready();
    @(posedge clk); #1;
    drive(1'b0, 32'h23, 32'h0, SIZE_BYTE, 1'b1);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", valid, 1'b1);
      check("stall_rdata", rdata, 32'hBEEFAA44);
      check("stall_ready", ready, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_ready", ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_valid();
    check("second_req_rdata", rdata, 32'h000000BE);

    // asynchronous reset during WAIT cancels the store
    st("st_word_30", 32'h30, 32'hCAFEF00D, SIZE_WORD, 1'b0);
    ld("ld_word_30", 32'h30, SIZE_WORD, 1'b0, 32'hCAFEF00D, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 32'h30, 32'h12345678, SIZE_WORD, 1'b0);
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    check("in_wait_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("async_reset_ctrl", {ready, valid, busy, err}, 4'b1000);
    check("async_reset_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    ld("ld_after_reset", 32'h30, SIZE_WORD, 1'b0, 32'hCAFEF00D, 1'b0);

    // zero-wait-state instance
    @(posedge clk); #1;
    sel = 1'b1;
    st("fast_st_40", 32'h40, 32'h0BADF00D, SIZE_WORD, 1'b0);
    xact(1'b0, 32'h40, 32'h0, SIZE_WORD, 1'b0, rd, er, lat);
    check("fast_ld_40_rdata", rd, 32'h0BADF00D);
    check("fast_ld_40_latency", lat, 1);
    ld("fast_ld_byte_41", 32'h41, SIZE_BYTE, 1'b0, 32'hFFFFFFF0, 1'b0);
    ld("fast_ld_half_42", 32'h42, SIZE_HALF, 1'b0, 32'h00000BAD, 1'b0);
    ld("fast_err_half_43", 32'h43, SIZE_HALF, 1'b0, 32'h0, 1'b1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
